// File: rtl/cd_clock_divider.sv
// Clock divider producing VGA, UART, LED-matrix and debouncer square waves from clk.
// Optional macro CD_VGA_SYNC_EN: pass clkinVGA through a 2-flop synchronizer in VGA mode 00.
`timescale 1ns/1ps
module cd_clock_divider #(
    parameter int UART_HALF_BASE = 4,
    parameter int LM_HALF        = 50,
    parameter int DB_HALF        = 1000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkinVGA,
    input  logic       c_valid,
    input  logic [3:0] c_addr,
    input  logic [7:0] c_data,
    output logic       c_ready,
    output logic       clk_VGA,
    output logic       clk_UART,
    output logic       clk_LM,
    output logic       clk_DB
);

    localparam logic [3:0]       ADDR_UART = 4'b0100;
    localparam logic [3:0]       ADDR_VGA  = 4'b1000;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LM_LAST   = CNT_W'(LM_HALF - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_HALF - 1);

    function automatic logic [CNT_W-1:0] uart_last(input logic [2:0] sel);
        logic [CNT_W-1:0] half;
        half = CNT_W'(UART_HALF_BASE) << sel;
        return half - CNT_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] vga_last(input logic [1:0] sel);
        logic [CNT_W-1:0] last;
        case (sel)
            2'b10:   last = CNT_W'(1);
            2'b11:   last = CNT_W'(3);
            default: last = '0;
        endcase
        return last;
    endfunction

    logic             r_c_ready;
    logic [2:0]       r_uart_sel;
    logic [CNT_W-1:0] r_uart_cnt;
    logic             r_uart_out;
    logic [1:0]       r_vga_sel;
    logic [CNT_W-1:0] r_vga_cnt;
    logic             r_vga_div;
    logic             r_vga_hold;
    logic [CNT_W-1:0] r_lm_cnt;
    logic             r_lm_out;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_db_out;

    logic             w_wr;
    logic             w_uart_wr;
    logic             w_uart_chg;
    logic             w_vga_wr;
    logic             w_vga_chg;
    logic [CNT_W-1:0] w_uart_last;
    logic [CNT_W-1:0] w_vga_last;
    logic             w_vga_src;
    logic             w_unused_data;

    assign w_wr        = c_valid && r_c_ready;
    assign w_uart_wr   = w_wr && (c_addr == ADDR_UART);
    assign w_vga_wr    = w_wr && (c_addr == ADDR_VGA);
    assign w_uart_chg  = w_uart_wr && (c_data[2:0] != r_uart_sel);
    assign w_vga_chg   = w_vga_wr && (c_data[1:0] != r_vga_sel);
    assign w_uart_last = uart_last(r_uart_sel);
    assign w_vga_last  = vga_last(r_vga_sel);
    assign w_unused_data = ^c_data[7:3];

    always_ff @(posedge clk) begin
        if (!rst) r_c_ready <= 1'b0;
        else      r_c_ready <= 1'b1;
    end

    // UART divider: a changed ratio restarts the wave low on the accepting edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_uart_sel <= 3'b000;
            r_uart_cnt <= '0;
            r_uart_out <= 1'b0;
        end else begin
            if (w_uart_wr) r_uart_sel <= c_data[2:0];
            if (w_uart_chg) begin
                r_uart_cnt <= '0;
                r_uart_out <= 1'b0;
            end else if (r_uart_cnt >= w_uart_last) begin
                r_uart_cnt <= '0;
                r_uart_out <= ~r_uart_out;
            end else begin
                r_uart_cnt <= r_uart_cnt + CNT_ONE;
            end
        end
    end

    // VGA: the hold flag blanks the output for one cycle after any mode change
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vga_sel  <= 2'b00;
            r_vga_cnt  <= '0;
            r_vga_div  <= 1'b0;
            r_vga_hold <= 1'b1;
        end else begin
            r_vga_hold <= w_vga_chg;
            if (w_vga_wr) r_vga_sel <= c_data[1:0];
            if (w_vga_chg || (r_vga_sel == 2'b00)) begin
                r_vga_cnt <= '0;
                r_vga_div <= 1'b0;
            end else if (r_vga_cnt >= w_vga_last) begin
                r_vga_cnt <= '0;
                r_vga_div <= ~r_vga_div;
            end else begin
                r_vga_cnt <= r_vga_cnt + CNT_ONE;
            end
        end
    end

`ifdef CD_VGA_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= clkinVGA;
            r_sync2 <= r_sync1;
        end
    end

    assign w_vga_src = r_sync2;
`else
    assign w_vga_src = clkinVGA;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lm_cnt <= '0;
            r_lm_out <= 1'b0;
        end else if (r_lm_cnt >= LM_LAST) begin
            r_lm_cnt <= '0;
            r_lm_out <= ~r_lm_out;
        end else begin
            r_lm_cnt <= r_lm_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_db_cnt <= '0;
            r_db_out <= 1'b0;
        end else if (r_db_cnt >= DB_LAST) begin
            r_db_cnt <= '0;
            r_db_out <= ~r_db_out;
        end else begin
            r_db_cnt <= r_db_cnt + CNT_ONE;
        end
    end

    assign c_ready  = r_c_ready;
    assign clk_UART = r_uart_out;
    assign clk_LM   = r_lm_out;
    assign clk_DB   = r_db_out;
    assign clk_VGA  = r_vga_hold ? 1'b0 :
                      ((r_vga_sel == 2'b00) ? w_vga_src : r_vga_div);

endmodule

// File: tb/tb_cd_clock_divider.sv
// Directed bench for cd_clock_divider: reset, UART ratios, VGA modes, ignored writes.
`timescale 1ns/1ps
module tb_cd_clock_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       clkinVGA;
    logic       c_valid;
    logic [3:0] c_addr;
    logic [7:0] c_data;
    logic       c_ready;
    logic       clk_VGA;
    logic       clk_UART;
    logic       clk_LM;
    logic       clk_DB;

    int checks = 0;
    int failures = 0;

    cd_clock_divider dut (
        .clk      (clk),
        .rst      (rst),
        .clkinVGA (clkinVGA),
        .c_valid  (c_valid),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_ready  (c_ready),
        .clk_VGA  (clk_VGA),
        .clk_UART (clk_UART),
        .clk_LM   (clk_LM),
        .clk_DB   (clk_DB)
    );

    // clk period 8; clkinVGA period 312 with edges offset from both clk edges
    always #4 clk = ~clk;

    initial begin
        clkinVGA = 1'b0;
        #1;
        forever #156 clkinVGA = ~clkinVGA;
    end

    int   ncyc = 0;
    logic p_uart = 1'b0, p_lm = 1'b0, p_db = 1'b0;
    int   uart_rise = -1, lm_rise = -1, db_rise = -1;

    always @(negedge clk) begin
        ncyc   <= ncyc + 1;
        p_uart <= (clk_UART === 1'b1);
        p_lm   <= (clk_LM === 1'b1);
        p_db   <= (clk_DB === 1'b1);
        if (!p_uart && clk_UART === 1'b1) uart_rise <= ncyc + 1;
        if (!p_lm && clk_LM === 1'b1)     lm_rise   <= ncyc + 1;
        if (!p_db && clk_DB === 1'b1)     db_rise   <= ncyc + 1;
    end

    time vga_prev = 0, vga_last = 0;
    int  vga_cnt = 0;

    always @(posedge clk_VGA) begin
        vga_prev <= vga_last;
        vga_last <= $time;
        vga_cnt  <= vga_cnt + 1;
    end

    logic h1 = 1'b0, h2 = 1'b0;

    always @(posedge clk) begin
        h1 <= clkinVGA;
        h2 <= h1;
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return clk_UART;
            1:       return clk_LM;
            2:       return clk_DB;
            default: return clk_VGA;
        endcase
    endfunction

    task automatic measure_period(input int which, input int budget, output int period);
        int   n;
        int   t0;
        logic prev;
        logic cur;
        n = 0;
        t0 = -1;
        period = -1;
        prev = (sig(which) === 1'b1);
        while (n < budget && period < 0) begin
            @(negedge clk);
            n++;
            cur = (sig(which) === 1'b1);
            if (!prev && cur) begin
                if (t0 < 0) t0 = n;
                else        period = n - t0;
            end
            prev = cur;
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d, input int n);
        c_valid = 1'b1;
        c_addr  = a;
        c_data  = d;
        repeat (n) @(negedge clk);
        c_valid = 1'b0;
    endtask

    task automatic test_reset;
        int p;
        int first_u;
        int first_l;
        rst = 1'b0;
        c_valid = 1'b0;
        c_addr = 4'h0;
        c_data = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({c_ready, clk_VGA, clk_UART, clk_LM, clk_DB} !== 5'b00000) begin
                failures++;
                $display("FAIL reset_outputs: got %b want 00000",
                         {c_ready, clk_VGA, clk_UART, clk_LM, clk_DB});
            end
        end
        rst = 1'b1;
        first_u = -1;
        first_l = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (c_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_after_reset: got %b want 1", c_ready);
                end
            end
            if (first_u < 0 && clk_UART === 1'b1) first_u = i;
            if (first_l < 0 && clk_LM === 1'b1)   first_l = i;
        end
        checks++;
        if (first_u != 4) begin
            failures++;
            $display("FAIL uart_first_rise: got %0d want 4", first_u);
        end
        checks++;
        if (first_l != 50) begin
            failures++;
            $display("FAIL lm_first_rise: got %0d want 50", first_l);
        end
        measure_period(0, 40, p);
        checks++;
        if (p != 8) begin
            failures++;
            $display("FAIL uart_period_default: got %0d want 8", p);
        end
        measure_period(1, 300, p);
        checks++;
        if (p != 100) begin
            failures++;
            $display("FAIL lm_period: got %0d want 100", p);
        end
        measure_period(2, 4500, p);
        checks++;
        if (p != 2000) begin
            failures++;
            $display("FAIL db_period: got %0d want 2000", p);
        end
    endtask

    task automatic test_uart_hold;
        int first;
        int p;
        first = -1;
        c_valid = 1'b1;
        c_addr = 4'b0100;
        c_data = 8'h04;
        for (int i = 0; i < 78; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (clk_UART !== 1'b0) begin
                    failures++;
                    $display("FAIL uart_restart_low: got %b want 0", clk_UART);
                end
            end
            if (first < 0 && clk_UART === 1'b1) first = i;
        end
        c_valid = 1'b0;
        checks++;
        if (first != 64) begin
            failures++;
            $display("FAIL uart_held_first_rise: got %0d want 64", first);
        end
        measure_period(0, 400, p);
        checks++;
        if (p != 128) begin
            failures++;
            $display("FAIL uart_period_sel4: got %0d want 128", p);
        end
    endtask

    task automatic test_uart_div4;
        int lm_ref;
        int db_ref;
        int first;
        int p;
        int n;
        lm_ref = lm_rise;
        db_ref = db_rise;
        cfg_write(4'b0100, 8'h02, 1);
        checks++;
        if (clk_UART !== 1'b0) begin
            failures++;
            $display("FAIL uart_sel2_restart: got %b want 0", clk_UART);
        end
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (first < 0 && clk_UART === 1'b1) first = i;
        end
        checks++;
        if (first != 16) begin
            failures++;
            $display("FAIL uart_sel2_first_rise: got %0d want 16", first);
        end
        measure_period(0, 100, p);
        checks++;
        if (p != 32) begin
            failures++;
            $display("FAIL uart_period_sel2: got %0d want 32", p);
        end
        n = 0;
        while (lm_rise <= lm_ref + 100 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (lm_rise <= lm_ref + 100 || ((lm_rise - lm_ref) % 100) != 0) begin
            failures++;
            $display("FAIL lm_phase: got rise %0d ref %0d want multiple of 100", lm_rise, lm_ref);
        end
        n = 0;
        while (db_rise <= db_ref && n < 4200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (db_rise <= db_ref || ((db_rise - db_ref) % 2000) != 0) begin
            failures++;
            $display("FAIL db_phase: got rise %0d ref %0d want multiple of 2000", db_rise, db_ref);
        end
    endtask

    task automatic test_vga;
        int   first;
        int   p;
        int   n;
        int   bad;
        int   c0;
        logic exp;
        cfg_write(4'b1000, 8'h02, 1);
        checks++;
        if (clk_VGA !== 1'b0) begin
            failures++;
            $display("FAIL vga_div4_start_low: got %b want 0", clk_VGA);
        end
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (first < 0 && clk_VGA === 1'b1) first = i;
        end
        checks++;
        if (first != 2) begin
            failures++;
            $display("FAIL vga_div4_first_rise: got %0d want 2", first);
        end
        measure_period(3, 20, p);
        checks++;
        if (p != 4) begin
            failures++;
            $display("FAIL vga_period_div4: got %0d want 4", p);
        end
        n = 0;
        while (clk_VGA !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        cfg_write(4'b1000, 8'h00, 1);
        checks++;
        if (clk_VGA !== 1'b0) begin
            failures++;
            $display("FAIL vga_switch_low: got %b want 0", clk_VGA);
        end
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
`ifdef CD_VGA_SYNC_EN
            exp = h2;
`else
            exp = clkinVGA;
`endif
            if (clk_VGA !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL vga_follow: got %0d mismatching cycles want 0", bad);
        end
        c0 = vga_cnt;
        n = 0;
        while (vga_cnt < c0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (vga_cnt < c0 + 3 || (vga_last - vga_prev) != 312) begin
            failures++;
            $display("FAIL vga_passthru_period: got %0t (rises %0d) want 312",
                     vga_last - vga_prev, vga_cnt - c0);
        end
    endtask

    task automatic test_bad_addr;
        int   u_ref;
        int   l_ref;
        int   t_end;
        int   n;
        int   bad;
        int   p;
        logic exp;
        u_ref = uart_rise;
        l_ref = lm_rise;
        cfg_write(4'b0011, 8'hFF, 6);
        t_end = ncyc;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
`ifdef CD_VGA_SYNC_EN
            exp = h2;
`else
            exp = clkinVGA;
`endif
            if (clk_VGA !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bad_addr_vga: got %0d mismatching cycles want 0", bad);
        end
        n = 0;
        while (uart_rise <= t_end && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (uart_rise <= t_end || ((uart_rise - u_ref) % 32) != 0) begin
            failures++;
            $display("FAIL bad_addr_uart_phase: got rise %0d ref %0d want multiple of 32",
                     uart_rise, u_ref);
        end
        n = 0;
        while (lm_rise <= t_end && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (lm_rise <= t_end || ((lm_rise - l_ref) % 100) != 0) begin
            failures++;
            $display("FAIL bad_addr_lm_phase: got rise %0d ref %0d want multiple of 100",
                     lm_rise, l_ref);
        end
        measure_period(0, 100, p);
        checks++;
        if (p != 32) begin
            failures++;
            $display("FAIL bad_addr_uart_period: got %0d want 32", p);
        end
    endtask

    task automatic test_reset_with_write;
        int first;
        int p;
        rst = 1'b0;
        c_valid = 1'b1;
        c_addr = 4'b0100;
        c_data = 8'h04;
        repeat (2) @(negedge clk);
        checks++;
        if ({c_ready, clk_VGA, clk_UART, clk_LM, clk_DB} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_write_outputs: got %b want 00000",
                     {c_ready, clk_VGA, clk_UART, clk_LM, clk_DB});
        end
        rst = 1'b1;
        c_valid = 1'b0;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (first < 0 && clk_UART === 1'b1) first = i;
        end
        checks++;
        if (first != 4) begin
            failures++;
            $display("FAIL reset_write_uart_first_rise: got %0d want 4", first);
        end
        measure_period(0, 40, p);
        checks++;
        if (p != 8) begin
            failures++;
            $display("FAIL reset_write_uart_period: got %0d want 8", p);
        end
    endtask

    initial begin
        rst = 1'b0;
        c_valid = 1'b0;
        c_addr = 4'h0;
        c_data = 8'h00;
        test_reset();
        test_uart_hold();
        test_uart_div4();
        test_vga();
        test_bad_addr();
        test_reset_with_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
